mdu: RTL
========

Name: mdu

Overview:
- Multi-cycle multiply/divide unit in the EX stage, beside the single-cycle ALU.
- Takes the same two 32-bit operands the ALU receives.
- Computes mult/multu/div/divu into internal HI/LO registers after a fixed latency.
- Serves mfhi/mflo reads and mthi/mtlo writes.
- Its busy flag feeds the hazard unit, which stalls later MDU instructions.

Parameters:
- MULT_CYCLES, 5: cycles from the launch edge to the edge that commits mult/multu results (≥1).
- DIV_CYCLES, 10: cycles from the launch edge to the edge that commits div/divu results (≥1).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- srcA  in  32  first operand: rs value, or the dividend.
- srcB  in  32  second operand: rt value, or the divisor.
- MDUOp  in  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others none.
- start  in  1  launch strobe for ops 1–4, one cycle.
- busy  out  1  registered; high while an operation is in flight.
- HI  out  32  current HI register.
- LO  out  32  current LO register.
- MDUResult  out  32  combinational: HI when MDUOp=5, LO when MDUOp=6, else 0.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-operation):
  - HI=0, LO=0, busy=0, cycle counter=0, latched operands/op cleared.
  - An in-flight result is discarded and never committed.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, counter counts down).
- Launch, IDLE→RUN:
  - Occurs at a rising edge with start=1, busy=0 and MDUOp in 1..4.
  - At that edge, latch srcA, srcB and MDUOp.
  - Load the counter with MULT_CYCLES-1 (ops 1,2) or DIV_CYCLES-1 (ops 3,4).
  - Set busy=1.
- RUN:
  - The counter decrements each edge.
  - On the edge where counter==0: commit HI/LO, busy→0, return to IDLE.
  - Net timing: launch at edge T; busy high from T until edge T+N (N = MULT_CYCLES or DIV_CYCLES); HI/LO change only at T+N.
  - The commit is visible in the cycle after edge T+N, when busy already reads 0.
- busy is registered and does not include the launch cycle. The hazard unit stalls on (start | busy).
- Ignored requests:
  - start while busy=1: ignored, no relaunch, latched operands unchanged.
  - start with MDUOp outside 1..4: ignored.
  - start=1 with MDUOp 7/8: the write still occurs (if busy=0).
- Arithmetic, using the latched operands:
  - mult: signed 32×32→64, HI=prod[63:32], LO=prod[31:0].
  - multu: unsigned, same split as mult.
  - div: signed. LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
    - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - divu: unsigned. LO=quotient, HI=remainder.
  - Divisor 0 (div/divu): the full DIV_CYCLES busy period still runs; HI and LO are left unchanged at commit.
- mthi/mtlo:
  - At a rising edge with busy=0 and MDUOp=7 (8), HI (LO) ← srcA.
  - Ignored while busy=1; the hazard unit guarantees none arrive then.
- mfhi/mflo: MDUResult reflects the HI/LO register contents, not the in-flight result.
- Same-edge commit and mthi/mtlo: cannot occur (busy=1 at that edge); the commit alone takes effect.
- Back-to-back: a new launch is accepted at edge T+N+1 at the earliest, i.e. the first edge where busy=0 is sampled.

Test Plan:
- Reset then mult 0xFFFFFFFF × 0x00000002 (signed) with start at edge T → busy=1 for 5 cycles; at T+5 HI=0xFFFFFFFF, LO=0xFFFFFFFE, busy=0.
- multu 0xFFFFFFFF × 0x00000002 → HI=0x00000001, LO=0xFFFFFFFE after 5 cycles; MDUOp=5 then gives MDUResult=0x00000001.
- div -7 (0xFFFFFFF9) / 2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 after mthi 0x1234 and mtlo 0x5678 → busy for 10 cycles; HI=0x1234 and LO=0x5678 unchanged.
- Launch div; pulse start with mult and different operands at cycle 3 → second start ignored; div result commits at T+10; busy never extends.
- Launch mult; drop rst_n at cycle 2 → busy, HI and LO go to 0 immediately without waiting for clk; no commit after release.
- Corner case: div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0, no X values.

Source files
------------

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Results commit a fixed number of cycles after launch.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic [3:0]  MDUOp,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUResult
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e        state_q;
  logic [3:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic          busy_q;

  logic          launch;
  logic          is_signed;
  logic          div_op;
  logic          div_zero;
  logic          a_neg;
  logic          b_neg;
  logic [63:0]   ea;
  logic [63:0]   eb;
  logic [63:0]   prod;
  logic [31:0]   ua;
  logic [31:0]   ub;
  logic [31:0]   ub_safe;
  logic [31:0]   uq;
  logic [31:0]   ur;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;

  assign launch = start &&
    (MDUOp == OP_MULT || MDUOp == OP_MULTU ||
     MDUOp == OP_DIV  || MDUOp == OP_DIVU);

  // Signed divide via magnitudes avoids the INT_MIN / -1 overflow trap.
  always_comb begin
    is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
    div_op    = (op_q == OP_DIV)  || (op_q == OP_DIVU);
    a_neg     = is_signed & a_q[31];
    b_neg     = is_signed & b_q[31];
    ea        = {{32{a_neg}}, a_q};
    eb        = {{32{b_neg}}, b_q};
    prod      = ea * eb;
    ua        = a_neg ? -a_q : a_q;
    ub        = b_neg ? -b_q : b_q;
    div_zero  = (b_q == 32'd0);
    ub_safe   = div_zero ? 32'd1 : ub;
    uq        = ua / ub_safe;
    ur        = ua % ub_safe;
    if (div_op) begin
      res_lo = (a_neg ^ b_neg) ? -uq : uq;
      res_hi = a_neg ? -ur : ur;
    end else begin
      res_lo = prod[31:0];
      res_hi = prod[63:32];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (launch) begin
            state_q <= RUN;
            op_q    <= MDUOp;
            a_q     <= srcA;
            b_q     <= srcB;
            busy_q  <= 1'b1;
            cnt_q   <= (MDUOp == OP_DIV || MDUOp == OP_DIVU)
                       ? DIV_LD : MULT_LD;
          end else if (MDUOp == OP_MTHI) begin
            hi_q <= srcA;
          end else if (MDUOp == OP_MTLO) begin
            lo_q <= srcA;
          end
        end
        RUN: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (!(div_op && div_zero)) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;
  assign MDUResult = (MDUOp == OP_MFHI) ? hi_q :
                     (MDUOp == OP_MFLO) ? lo_q : 32'd0;

endmodule
